// File: rtl/lsa_pkg.sv
// Shared types and elaboration helpers for the two-phase latch shift array.
package lsa_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    GAP1 = 3'd2,
    PH2  = 3'd3,
    GAP2 = 3'd4
  } lsa_state_t;

  // Gap counter runs 0..gap-1; keep at least one bit so GAP=1 still elaborates.
  function automatic int gap_cnt_w(input int gap);
    return (gap > 1) ? $clog2(gap) : 1;
  endfunction

  function automatic int tap_sel_w(input int depth);
    return (depth > 2) ? $clog2(depth / 2) : 1;
  endfunction

  function automatic int fill_w(input int depth);
    return $clog2(depth / 2 + 1);
  endfunction

  function automatic bit params_legal(input int width, input int depth, input int gap);
    return (width >= 1) && (depth >= 2) && (depth % 2 == 0) && (gap >= 1);
  endfunction

endpackage

// File: rtl/lsa_latch.sv
// WIDTH-bit transparent latch with level enable and asynchronous active-high clear.
module lsa_latch #(
  parameter int WIDTH = 1
) (
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_latch begin
    if (i_clr)
      o_q <= '0;
    else if (i_en)
      o_q <= i_d;
  end

endmodule

// File: rtl/lsa_shift_array.sv
// Two-phase latch shift array with request/ack sequencer and fill tracking.
// Optional tap readout port enabled by defining LSA_TAP_EN.
module lsa_shift_array
  import lsa_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 128,
  parameter int GAP   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        shift_req,
  input  logic [WIDTH-1:0]            din,
  output logic                        shift_ack,
  output logic                        busy,
  output logic [WIDTH-1:0]            dout,
`ifdef LSA_TAP_EN
  input  logic [tap_sel_w(DEPTH)-1:0] tap_sel,
  output logic [WIDTH-1:0]            tap_out,
`endif
  output logic                        out_valid
);

  localparam int                GW       = gap_cnt_w(GAP);
  localparam int                FW       = fill_w(DEPTH);
  localparam logic [GW-1:0]     GAP_LAST = GW'(GAP - 1);
  localparam logic [FW-1:0]     FULL     = FW'(DEPTH / 2);

  if (!params_legal(WIDTH, DEPTH, GAP)) begin : g_bad_params
    $error("lsa_shift_array: DEPTH must be even and >=2, GAP and WIDTH >=1");
  end

  lsa_state_t       r_state;
  lsa_state_t       w_next;
  logic [GW-1:0]    r_gap_cnt;
  logic             w_gap_done;
  logic             w_accept;
  logic             w_done;
  logic             r_clk1;
  logic             r_clk2;
  logic             r_ack;
  logic [WIDTH-1:0] r_din_q;
  logic [FW-1:0]    r_fill;

  always_comb begin
    w_next     = r_state;
    w_gap_done = (r_gap_cnt == GAP_LAST);
    w_accept   = (r_state == IDLE) && shift_req;
    w_done     = (r_state == GAP2) && w_gap_done;
    case (r_state)
      IDLE:    if (shift_req)  w_next = PH1;
      PH1:                     w_next = GAP1;
      GAP1:    if (w_gap_done) w_next = PH2;
      PH2:                     w_next = GAP2;
      GAP2:    if (w_gap_done) w_next = IDLE;
      default:                 w_next = IDLE;
    endcase
  end

  // Phase enables are registered from the next state so they are glitch-free flop outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_gap_cnt <= '0;
      r_clk1    <= 1'b0;
      r_clk2    <= 1'b0;
      r_ack     <= 1'b0;
      r_din_q   <= '0;
      r_fill    <= '0;
    end else begin
      r_state <= w_next;
      r_clk1  <= (w_next == PH1);
      r_clk2  <= (w_next == PH2);
      r_ack   <= w_done;
      if (w_accept)
        r_din_q <= din;
      if (((r_state == GAP1) || (r_state == GAP2)) && !w_gap_done)
        r_gap_cnt <= r_gap_cnt + 1'b1;
      else
        r_gap_cnt <= '0;
      if (w_done && (r_fill != FULL))
        r_fill <= r_fill + 1'b1;
    end
  end

  assign shift_ack = r_ack;
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_fill == FULL);

`ifdef LSA_TAP_EN
  logic [WIDTH-1:0] w_words [DEPTH/2];
`endif

  // Even stages open on clk1, odd on clk2; the phases never overlap, so no path races through.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] w_q;
    if (i == 0) begin : g_head
      assign w_d = r_din_q;
    end else begin : g_link
      assign w_d = g_stage[i-1].w_q;
    end
    lsa_latch #(.WIDTH(WIDTH)) u_latch (
      .i_en  ((i % 2 == 0) ? r_clk1 : r_clk2),
      .i_clr (rst),
      .i_d   (w_d),
      .o_q   (w_q)
    );
`ifdef LSA_TAP_EN
    if (i % 2 == 1) begin : g_tap
      assign w_words[i/2] = w_q;
    end
`endif
  end

  assign dout = g_stage[DEPTH-1].w_q;

`ifdef LSA_TAP_EN
  assign tap_out = w_words[tap_sel];
`endif

endmodule

// File: tb/tb_lsa_shift_array.sv
// Directed self-checking bench for lsa_shift_array (WIDTH=4, DEPTH=8, GAP=1).
// Tap checks are compiled in when LSA_TAP_EN is defined.
module tb_lsa_shift_array;

  logic       clk;
  logic       rst;
  logic       shift_req;
  logic [3:0] din;
  logic       shift_ack;
  logic       busy;
  logic [3:0] dout;
  logic       out_valid;
`ifdef LSA_TAP_EN
  logic [1:0] tap_sel;
  logic [3:0] tap_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  lsa_shift_array #(.WIDTH(4), .DEPTH(8), .GAP(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .shift_req (shift_req),
    .din       (din),
    .shift_ack (shift_ack),
    .busy      (busy),
    .dout      (dout),
`ifdef LSA_TAP_EN
    .tap_sel   (tap_sel),
    .tap_out   (tap_out),
`endif
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Caller is in IDLE, #1 after an edge; returns #1 after the ack edge.
  task automatic do_shift(input logic [3:0] w);
    logic got;
    din       = w;
    shift_req = 1'b1;
    @(posedge clk); #1;
    shift_req = 1'b0;
    din       = 4'hF;
    got       = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge clk); #1;
      if (shift_ack) got = 1'b1;
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
  endtask

  logic [14:0] clk1_mask;
  logic [14:0] ack_mask;
  logic        busy_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; shift_req = 1'b0; din = 4'h0;
`ifdef LSA_TAP_EN
    tap_sel = 2'd0;
`endif
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_ack",   {31'd0, shift_ack}, 32'd0);
    chk("rst_dout",  {28'd0, dout},      32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic fill
    do_shift(4'h1);
    do_shift(4'h2);
    do_shift(4'h3);
    chk("fill3_valid", {31'd0, out_valid}, 32'd0);
    do_shift(4'h4);
    chk("fill4_valid", {31'd0, out_valid}, 32'd1);
    chk("fill4_dout",  {28'd0, dout},      32'h1);
    do_shift(4'h5);
    chk("push5_dout",  {28'd0, dout},      32'h2);

    // phase timing: accept word 6 at cycle t
    din = 4'h6; shift_req = 1'b1;
    @(posedge clk); #1;
    shift_req = 1'b0; din = 4'h0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("ph_clk1_t%0d", k), {31'd0, dut.r_clk1}, (k == 1) ? 32'd1 : 32'd0);
      chk($sformatf("ph_clk2_t%0d", k), {31'd0, dut.r_clk2}, (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("ph_busy_t%0d", k), {31'd0, busy},       (k <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("ph_ack_t%0d", k),  {31'd0, shift_ack},  (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("ph_dout_t%0d", k), {28'd0, dout},       (k >= 3) ? 32'h3 : 32'h2);
      @(posedge clk); #1;
    end

    // back-to-back: words 7, 8, 9
    din = 4'h7; shift_req = 1'b1;
    clk1_mask = '0; ack_mask = '0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      clk1_mask[c] = dut.r_clk1;
      ack_mask[c]  = shift_ack;
      if (c == 0) din = 4'h8;
      if (c == 5) din = 4'h9;
      if (c == 10) shift_req = 1'b0;
    end
    chk("b2b_accepts", {17'd0, clk1_mask}, 32'h0421);
    chk("b2b_acks",    {17'd0, ack_mask},  32'h4210);
    chk("b2b_dout",    {28'd0, dout},      32'h6);
    chk("b2b_valid",   {31'd0, out_valid}, 32'd1);

    // reset during GAP1 of a shift
    din = 4'hB; shift_req = 1'b1;
    @(posedge clk); #1;
    shift_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_clk1",  {31'd0, dut.r_clk1}, 32'd0);
    chk("mid_rst_clk2",  {31'd0, dut.r_clk2}, 32'd0);
    chk("mid_rst_dout",  {28'd0, dout},       32'd0);
    chk("mid_rst_fill",  {29'd0, dut.r_fill}, 32'd0);
    chk("mid_rst_valid", {31'd0, out_valid},  32'd0);
    chk("mid_rst_busy",  {31'd0, busy},       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_shift(4'hC);
    chk("post_rst_fill", {29'd0, dut.r_fill}, 32'd1);

    // request while busy is ignored
    din = 4'hA; shift_req = 1'b1;
    @(posedge clk); #1;
    shift_req = 1'b0;
    @(posedge clk); #1;
    shift_req = 1'b1;
    @(posedge clk); #1;
    shift_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy_req_ack", {31'd0, shift_ack}, 32'd1);
    busy_seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (busy) busy_seen = 1'b1;
    end
    chk("busy_req_ignored", {31'd0, busy_seen},  32'd0);
    chk("busy_req_fill",    {29'd0, dut.r_fill}, 32'd2);

    // refill with A..D
    do_shift(4'hA);
    do_shift(4'hB);
    do_shift(4'hC);
    do_shift(4'hD);
    chk("abcd_valid", {31'd0, out_valid}, 32'd1);
    chk("abcd_dout",  {28'd0, dout},      32'hA);
`ifdef LSA_TAP_EN
    tap_sel = 2'd0; #1;
    chk("tap0", {28'd0, tap_out}, 32'hD);
    tap_sel = 2'd1; #1;
    chk("tap1", {28'd0, tap_out}, 32'hC);
    tap_sel = 2'd3; #1;
    chk("tap3", {28'd0, tap_out}, 32'hA);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
